ldm_stm_sequencer: RTL and testbench

Multi-register transfer sequencer for the Cortex-M style core. It executes LDM/STM (and PUSH/POP as DB/IA forms) by walking a 16-bit register list. For stores it drives the register file read port; for loads it drives the register file write port. It issues one word-wide memory request per listed register, then optionally writes the updated base register back.

---
 rtl/ldm_stm_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_ldm_stm_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ldm_stm_sequencer.sv
// ---------------------------------------------------------------------------
// ldm_stm_sequencer
//
// Purpose:
//    Executes LDM/STM (and PUSH/POP as their DB/IA forms) by walking a 16-bit
//    register list. One word-wide memory request is issued per listed
//    register, lowest register first, at ascending addresses. Stores source
//    their data from register file read port 1. Loads return data through
//    the register file write port one cycle after each ack. The updated base
//    is optionally written back once the transfer completes.
//
// Ports:
//    clk, rst          core clock, synchronous active-high reset
//    start             launch a transfer (sampled only while idle)
//    is_load           1 = LDM, 0 = STM
//    mode_db           0 = increment-after, 1 = decrement-before
//    writeback         write the final base to base_reg
//    base_reg          register index that receives the writeback
//    base_addr         base address (bits [1:0] ignored)
//    reg_list          bit k set = register Rk is transferred
//    busy              high from the cycle after start through the done cycle
//    done              single-cycle completion pulse
//    rf_read_addr      register file read address (store data)
//    rf_read_data      combinational register file read data
//    rf_write_addr/data/en   register file write port
//    mem_req/we/addr/wdata   memory request, held until mem_ack
//    mem_ack           request accepted; load data valid in the same cycle
//    mem_rdata         load data
// ---------------------------------------------------------------------------
module ldm_stm_sequencer #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              is_load,
   input  logic              mode_db,
   input  logic              writeback,
   input  logic [3:0]        base_reg,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [15:0]       reg_list,
   output logic              busy,
   output logic              done,
   output logic [3:0]        rf_read_addr,
   input  logic [31:0]       rf_read_data,
   output logic [3:0]        rf_write_addr,
   output logic [31:0]       rf_write_data,
   output logic              rf_write_en,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ack,
   input  logic [31:0]       mem_rdata
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      XFER  = 2'd1,
      LAST  = 2'd2,
      WBASE = 2'd3
   } state_t;

   state_t            state;
   logic [15:0]       list_q;
   logic              is_load_q;
   logic              do_wb_q;
   logic [3:0]        base_reg_q;
   logic [ADDR_W-1:0] final_base_q;

   logic [3:0]        cur_reg;
   logic [15:0]       cur_mask;
   logic [15:0]       list_next;
   logic [4:0]        reg_count;
   logic [ADDR_W-1:0] aligned_base;
   logic [ADDR_W-1:0] four_n;
   logic [ADDR_W-1:0] db_addr;
   logic [ADDR_W-1:0] ia_final;

   function automatic logic [4:0] popcount16(input logic [15:0] v);
      logic [4:0] n;
      n = 5'd0;
      for (int i = 0; i < 16; i++) begin
         n = n + {4'd0, v[i]};
      end
      return n;
   endfunction

   // Scanning downward lets the lowest set bit overwrite any higher one.
   function automatic logic [3:0] lowest_index(input logic [15:0] v);
      logic [3:0] idx;
      idx = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (v[i]) begin
            idx = 4'(i);
         end
      end
      return idx;
   endfunction

   // Address arithmetic for the launch: both DB start address and DB final
   // base are base - 4N; IA starts at base and ends at base + 4N. All of it
   // wraps modulo 2^ADDR_W.
   always_comb begin
      reg_count    = popcount16(reg_list);
      aligned_base = base_addr & ~ADDR_W'(3);
      four_n       = ADDR_W'({reg_count, 2'b00});
      db_addr      = aligned_base - four_n;
      ia_final     = aligned_base + four_n;
   end

   // The current register is the lowest bit still pending; two's-complement
   // isolation gives its one-hot mask for clearing on ack.
   always_comb begin
      cur_reg   = lowest_index(list_q);
      cur_mask  = list_q & (~list_q + 16'd1);
      list_next = list_q & ~cur_mask;
   end

   // Read port and store data follow the pending register directly so the
   // register file read stays combinational; both are forced to zero outside
   // XFER so that every output is quiet while idle.
   always_comb begin
      rf_read_addr = 4'd0;
      mem_wdata    = 32'd0;
      if (state == XFER) begin
         rf_read_addr = cur_reg;
         if (!is_load_q) begin
            mem_wdata = rf_read_data;
         end
      end
   end

   // Main sequencer. The register file write strobe is a one-cycle pulse by
   // default; a load write is scheduled on each ack and the base writeback
   // is scheduled on leaving LAST, so the two can never collide. A load that
   // includes base_reg suppresses the writeback at launch time so that the
   // loaded value survives.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         list_q        <= 16'd0;
         is_load_q     <= 1'b0;
         do_wb_q       <= 1'b0;
         base_reg_q    <= 4'd0;
         final_base_q  <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         mem_req       <= 1'b0;
         mem_we        <= 1'b0;
         mem_addr      <= '0;
         rf_write_en   <= 1'b0;
         rf_write_addr <= 4'd0;
         rf_write_data <= 32'd0;
      end else begin
         rf_write_en   <= 1'b0;
         rf_write_addr <= 4'd0;
         rf_write_data <= 32'd0;
         case (state)
            IDLE: begin
               if (start) begin
                  busy <= 1'b1;
                  if (reg_list != 16'd0) begin
                     state        <= XFER;
                     list_q       <= reg_list;
                     is_load_q    <= is_load;
                     base_reg_q   <= base_reg;
                     do_wb_q      <= writeback & ~(is_load & reg_list[base_reg]);
                     final_base_q <= mode_db ? db_addr : ia_final;
                     mem_req      <= 1'b1;
                     mem_we       <= ~is_load;
                     mem_addr     <= mode_db ? db_addr : aligned_base;
                  end else begin
                     state   <= WBASE;
                     done    <= 1'b1;
                     do_wb_q <= 1'b0;
                  end
               end
            end

            XFER: begin
               if (mem_ack) begin
                  list_q <= list_next;
                  if (is_load_q) begin
                     rf_write_en   <= 1'b1;
                     rf_write_addr <= cur_reg;
                     rf_write_data <= mem_rdata;
                  end
                  if (list_next == 16'd0) begin
                     state    <= LAST;
                     mem_req  <= 1'b0;
                     mem_we   <= 1'b0;
                     mem_addr <= '0;
                  end else begin
                     mem_addr <= mem_addr + ADDR_W'(4);
                  end
               end
            end

            LAST: begin
               state <= WBASE;
               done  <= 1'b1;
               if (do_wb_q) begin
                  rf_write_en   <= 1'b1;
                  rf_write_addr <= base_reg_q;
                  rf_write_data <= 32'(final_base_q);
               end
            end

            WBASE: begin
               state        <= IDLE;
               busy         <= 1'b0;
               done         <= 1'b0;
               list_q       <= 16'd0;
               is_load_q    <= 1'b0;
               do_wb_q      <= 1'b0;
               base_reg_q   <= 4'd0;
               final_base_q <= '0;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ldm_stm_sequencer
//
// Directed bench for ldm_stm_sequencer. The bench owns a 16-entry register
// file and a simple memory responder with a configurable number of wait
// cycles per request. Each transfer is launched by applyStimulus, which
// records store traffic, load addresses, register writes and cycle numbers
// (cycle 1 = first cycle after the edge that samples start). Expected
// values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_ldm_stm_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        is_load;
   logic        mode_db;
   logic        writeback;
   logic [3:0]  base_reg;
   logic [31:0] base_addr;
   logic [15:0] reg_list;
   logic        busy;
   logic        done;
   logic [3:0]  rf_read_addr;
   logic [31:0] rf_read_data;
   logic [3:0]  rf_write_addr;
   logic [31:0] rf_write_data;
   logic        rf_write_en;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   logic [31:0] regs [16];

   int errors = 0;
   int checks = 0;

   int          doneCycle;
   int          busyCycles;
   int          reqCycles;
   int          rfWrites;
   int          rfWritesAfterRst;
   int          rstCycle;
   bit          stable;
   logic [31:0] stAddr [$];
   logic [31:0] stData [$];
   logic [31:0] ldAddr [$];
   logic [31:0] rdataQ [$];
   int          wrCycle [$];

   always #5 clk = ~clk;

   assign rf_read_data = regs[rf_read_addr];

   ldm_stm_sequencer #(.ADDR_W(32)) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .is_load       (is_load),
      .mode_db       (mode_db),
      .writeback     (writeback),
      .base_reg      (base_reg),
      .base_addr     (base_addr),
      .reg_list      (reg_list),
      .busy          (busy),
      .done          (done),
      .rf_read_addr  (rf_read_addr),
      .rf_read_data  (rf_read_data),
      .rf_write_addr (rf_write_addr),
      .rf_write_data (rf_write_data),
      .rf_write_en   (rf_write_en),
      .mem_req       (mem_req),
      .mem_we        (mem_we),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_ack       (mem_ack),
      .mem_rdata     (mem_rdata)
   );

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      end
   endtask

   // Every DUT output must be zero while idle or just after reset.
   task automatic checkQuiet(input string tag);
      checkOutput({tag, "_ctl"}, {27'd0, busy, done, mem_req, mem_we, rf_write_en}, 32'd0);
      checkOutput({tag, "_maddr"}, mem_addr, 32'd0);
      checkOutput({tag, "_wdata"}, mem_wdata, 32'd0);
      checkOutput({tag, "_rfw"}, {rf_write_addr, rf_write_data[27:0]} | {28'd0, rf_read_addr}, 32'd0);
   endtask

   // Launches one transfer and runs it to completion, acting as the memory
   // and register file. resetReq > 0 asserts reset in the first cycle of
   // that request; holdStart keeps start high (with a non-empty list) for
   // one extra cycle to probe the busy guard.
   task automatic applyStimulus(input bit load, input bit db, input bit wb,
                                input logic [3:0] breg, input logic [31:0] base,
                                input logic [15:0] list, input int waits,
                                input int resetReq, input bit holdStart);
      int          cyc;
      int          waitCnt;
      int          reqIdx;
      int          endCycle;
      logic [31:0] holdAddr;
      logic [3:0]  holdRa;
      logic        holdWe;
      doneCycle = -1;
      busyCycles = 0;
      reqCycles = 0;
      rfWrites = 0;
      rfWritesAfterRst = 0;
      rstCycle = -1;
      stable = 1'b1;
      stAddr.delete();
      stData.delete();
      ldAddr.delete();
      wrCycle.delete();
      cyc = 0;
      waitCnt = 0;
      reqIdx = 0;
      endCycle = -1;
      holdAddr = 32'd0;
      holdRa = 4'd0;
      holdWe = 1'b0;

      @(negedge clk);
      is_load = load;
      mode_db = db;
      writeback = wb;
      base_reg = breg;
      base_addr = base;
      reg_list = list;
      start = 1'b1;
      @(posedge clk);
      #1;
      if (holdStart) reg_list = 16'h0001;
      else start = 1'b0;

      forever begin
         @(negedge clk);
         cyc++;
         if (holdStart && cyc == 2) start = 1'b0;
         if (busy) busyCycles++;
         if (done && doneCycle < 0) doneCycle = cyc;
         if (rf_write_en) begin
            regs[rf_write_addr] = rf_write_data;
            rfWrites++;
            wrCycle.push_back(cyc);
            if (rstCycle > 0) rfWritesAfterRst++;
         end
         if (rstCycle > 0 && cyc == rstCycle + 1) begin
            rst = 1'b0;
            checkQuiet("rst_mid");
         end
         mem_ack = 1'b0;
         if (mem_req) begin
            reqCycles++;
            if (resetReq > 0 && reqIdx == resetReq - 1 && waitCnt == 0 && rstCycle < 0) begin
               rst = 1'b1;
               rstCycle = cyc;
            end else if (rstCycle < 0) begin
               if (waitCnt == 0) begin
                  holdAddr = mem_addr;
                  holdRa = rf_read_addr;
                  holdWe = mem_we;
               end else if (mem_addr !== holdAddr || rf_read_addr !== holdRa || mem_we !== holdWe) begin
                  stable = 1'b0;
               end
               if (waitCnt == waits) begin
                  mem_ack = 1'b1;
                  waitCnt = 0;
                  reqIdx++;
                  if (mem_we) begin
                     stAddr.push_back(mem_addr);
                     stData.push_back(mem_wdata);
                  end else begin
                     ldAddr.push_back(mem_addr);
                     mem_rdata = (rdataQ.size() > 0) ? rdataQ.pop_front() : 32'd0;
                  end
               end else begin
                  waitCnt++;
               end
            end
         end
         if (!busy && doneCycle >= 0 && endCycle < 0) endCycle = cyc + 2;
         if (cyc == endCycle) break;
         if (rstCycle > 0 && cyc == rstCycle + 4) break;
         if (cyc >= 200) begin
            checkOutput("timeout", 32'd1, 32'd0);
            break;
         end
      end
      start = 1'b0;
      mem_ack = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      is_load = 1'b0;
      mode_db = 1'b0;
      writeback = 1'b0;
      base_reg = 4'd0;
      base_addr = 32'd0;
      reg_list = 16'd0;
      mem_ack = 1'b0;
      mem_rdata = 32'd0;
      for (int i = 0; i < 16; i++) regs[i] = 32'd0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      checkQuiet("reset");
      rst = 1'b0;

      // STM IA, base 0x1000, R1/R2/R4, writeback into R0: final 0x100C.
      regs[1] = 32'd2;
      regs[2] = 32'd3;
      regs[4] = 32'd5;
      applyStimulus(1'b0, 1'b0, 1'b1, 4'd0, 32'h1000, 16'h0016, 0, 0, 1'b0);
      checkOutput("t1_nstore", stAddr.size(), 32'd3);
      checkOutput("t1_a0", stAddr[0], 32'h1000);
      checkOutput("t1_d0", stData[0], 32'd2);
      checkOutput("t1_a1", stAddr[1], 32'h1004);
      checkOutput("t1_d1", stData[1], 32'd3);
      checkOutput("t1_a2", stAddr[2], 32'h1008);
      checkOutput("t1_d2", stData[2], 32'd5);
      checkOutput("t1_r0", regs[0], 32'h100C);
      checkOutput("t1_done", doneCycle, 32'd5);
      checkOutput("t1_busy", busyCycles, 32'd5);
      checkQuiet("t1_idle");

      // LDM DB, base 0x2000, R0/R6/R7, writeback into R8: start/final 0x1FF4.
      regs[8] = 32'h8888;
      rdataQ = '{32'hA0, 32'hA6, 32'hA7};
      applyStimulus(1'b1, 1'b1, 1'b1, 4'd8, 32'h2000, 16'h00C1, 0, 0, 1'b0);
      checkOutput("t2_nload", ldAddr.size(), 32'd3);
      checkOutput("t2_a0", ldAddr[0], 32'h1FF4);
      checkOutput("t2_a1", ldAddr[1], 32'h1FF8);
      checkOutput("t2_a2", ldAddr[2], 32'h1FFC);
      checkOutput("t2_r0", regs[0], 32'hA0);
      checkOutput("t2_r6", regs[6], 32'hA6);
      checkOutput("t2_r7", regs[7], 32'hA7);
      checkOutput("t2_r8", regs[8], 32'h1FF4);
      checkOutput("t2_wr_lag", wrCycle[0], 32'd2);
      checkOutput("t2_wb_cyc", wrCycle[3], 32'd5);
      checkOutput("t2_done", doneCycle, 32'd5);

      // STM IA with three wait cycles per request: two requests of four
      // cycles each fill XFER cycles 1..8, LAST is 9, done is 10.
      regs[0] = 32'h11;
      regs[1] = 32'h22;
      applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 32'h3000, 16'h0003, 3, 0, 1'b0);
      checkOutput("t3_a0", stAddr[0], 32'h3000);
      checkOutput("t3_d0", stData[0], 32'h11);
      checkOutput("t3_a1", stAddr[1], 32'h3004);
      checkOutput("t3_d1", stData[1], 32'h22);
      checkOutput("t3_stable", {31'd0, stable}, 32'd1);
      checkOutput("t3_reqcyc", reqCycles, 32'd8);
      checkOutput("t3_done", doneCycle, 32'd10);
      checkOutput("t3_nowr", rfWrites, 32'd0);

      // LDM IA that loads its own base register: loaded value wins.
      regs[3] = 32'h4000;
      rdataQ = '{32'hDEAD};
      applyStimulus(1'b1, 1'b0, 1'b1, 4'd3, 32'h4000, 16'h0008, 0, 0, 1'b0);
      checkOutput("t4_r3", regs[3], 32'hDEAD);
      checkOutput("t4_nwr", rfWrites, 32'd1);
      checkOutput("t4_done", doneCycle, 32'd3);

      // Empty list with start held into the busy cycle.
      regs[5] = 32'h5555;
      applyStimulus(1'b0, 1'b0, 1'b1, 4'd5, 32'h5000, 16'h0000, 0, 0, 1'b1);
      checkOutput("t5_done", doneCycle, 32'd1);
      checkOutput("t5_busy", busyCycles, 32'd1);
      checkOutput("t5_noreq", reqCycles, 32'd0);
      checkOutput("t5_nowr", rfWrites, 32'd0);
      checkOutput("t5_r5", regs[5], 32'h5555);

      // Reset in the first cycle of the 2nd request of a 4-register LDM.
      for (int i = 0; i < 4; i++) regs[i] = 32'h100 + 32'(i);
      rdataQ = '{32'hB0, 32'hB1, 32'hB2, 32'hB3};
      applyStimulus(1'b1, 1'b0, 1'b1, 4'd0, 32'h5000, 16'h000F, 1, 2, 1'b0);
      checkOutput("t6_r0", regs[0], 32'hB0);
      checkOutput("t6_r1", regs[1], 32'h101);
      checkOutput("t6_after", rfWritesAfterRst, 32'd0);
      checkOutput("t6_nodone", {31'd0, doneCycle < 0}, 32'd1);
      checkOutput("t6_nload", ldAddr.size(), 32'd1);

      // A following STM must run normally.
      regs[0] = 32'h77;
      regs[2] = 32'h99;
      rdataQ.delete();
      applyStimulus(1'b0, 1'b0, 1'b1, 4'd1, 32'h6000, 16'h0005, 0, 0, 1'b0);
      checkOutput("t7_a0", stAddr[0], 32'h6000);
      checkOutput("t7_d0", stData[0], 32'h77);
      checkOutput("t7_a1", stAddr[1], 32'h6004);
      checkOutput("t7_d1", stData[1], 32'h99);
      checkOutput("t7_r1", regs[1], 32'h6008);
      checkOutput("t7_done", doneCycle, 32'd4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
